// File: rtl/uart_tx_port_pkg.sv
// Shared definitions for the UART TX port: I/O window codes, register offsets,
// STATUS bit layout and transmitter state encodings.
package uart_tx_port_pkg;

    // Processor I/O windows selected by ADDR[8:7]; the UART sits in the last one.
    typedef enum logic [1:0] {
        IO_SRAM = 2'b00,
        IO_MODE = 2'b01,
        IO_GPIO = 2'b10,
        IO_UART = 2'b11
    } io_win_e;

    typedef enum logic {
        UART_DATA = 1'b0,
        UART_STAT = 1'b1
    } uart_reg_e;

    localparam int STAT_BUSY  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_FULL  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } tx_state_e;

    function automatic logic [8:0] stat_word(input logic ovf, input logic full,
                                             input logic empty, input logic busy);
        logic [8:0] w;
        w = '0;
        w[STAT_OVF]   = ovf;
        w[STAT_FULL]  = full;
        w[STAT_EMPTY] = empty;
        w[STAT_BUSY]  = busy;
        return w;
    endfunction

endpackage

// File: rtl/uart_tx_port_sync_fifo.sv
// Single-clock FIFO with occupancy count; push to full / pop from empty are ignored.
// DEPTH must be a power of two so the pointers wrap for free.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == DEPTH[AW:0]);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty/count gate every read of it.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped 8N1 UART transmitter: DATA register feeds a TX FIFO, STATUS reports
// busy/empty/full/overflow. rdata is a combinational read-back selected by reg_sel.
module uart_tx_port
    import uart_tx_port_pkg::*;
#(
    parameter int CLKS_PER_BIT = 234,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       reg_sel,
    input  logic [8:0] wdata,
    output logic [8:0] rdata,
    output logic       tx
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLKS_PER_BIT - 1);

    tx_state_e      state;
    logic [BW-1:0]  baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           overflow;

    logic           push, pop, fifo_full, fifo_empty, baud_done, busy;
    logic [7:0]     fifo_head;
    logic [CW-1:0]  fifo_count;
    logic           unused_wdata;

    assign unused_wdata = wdata[8];
    assign push      = wr_en && (reg_sel == UART_DATA);
    assign baud_done = (baud_cnt == BAUD_MAX);
    assign busy      = (state != ST_IDLE);
    // The FSM takes the head either from idle or at the tail of a stop bit.
    assign pop       = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && baud_done));

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (wdata[7:0]),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && (reg_sel == UART_STAT) && wdata[0]) begin
            overflow <= 1'b0;
        end else if (push && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shift <= fifo_head;
                        state <= ST_START;
                        tx    <= 1'b0;
                    end
                end
                ST_START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_STOP;
                            tx    <= 1'b1;
                        end else begin
                            // tx is registered, so drive the bit that the shift exposes next.
                            shift   <= {1'b0, shift[7:1]};
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift <= fifo_head;
                            state <= ST_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

    assign rdata = (reg_sel == UART_STAT)
                 ? stat_word(overflow, fifo_full, fifo_empty, busy)
                 : 9'(fifo_count);

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed bench for uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
module tb_uart_tx_port;
    logic       clock = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       reg_sel;
    logic [8:0] wdata;
    logic [8:0] rdata;
    logic       tx;

    int tests = 0;
    int fails = 0;
    logic [7:0] exp_bytes [8];
    logic [8:0] v;
    logic       line_ok;

    uart_tx_port #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (wr_en),
        .reg_sel (reg_sel),
        .wdata   (wdata),
        .rdata   (rdata),
        .tx      (tx)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic sel, input logic [8:0] d);
        wr_en   = 1'b1;
        reg_sel = sel;
        wdata   = d;
        @(posedge clock);
        #1;
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic sel, output logic [8:0] val);
        reg_sel = sel;
        #1;
        val = rdata;
    endtask

    // Line level k cycles after the first pop edge, frames laid back to back.
    function automatic logic exp_bit(input int k);
        int idx, pos;
        idx = k / 40;
        pos = (k % 40) / 4;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return exp_bytes[idx][pos-1];
    endfunction

    // Advance from frame position k_from to k_to, checking mid-bit line levels.
    task automatic run_tx(input int k_from, input int k_to, input string tag);
        for (int k = k_from; k < k_to; k++) begin
            if (k % 4 == 2) check($sformatf("%s_k%0d", tag, k), {8'b0, tx}, {8'b0, exp_bit(k)});
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; wr_en = 1'b0; reg_sel = 1'b0; wdata = '0;
        #1;
        check("rst_tx", {8'b0, tx}, 9'h001);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        rd(1'b0, v); check("idle_data", v, 9'h000);
        rd(1'b1, v); check("idle_stat", v, 9'h002);

        // Single frame 0xA5; wdata[8] must be ignored.
        exp_bytes[0] = 8'hA5;
        wr(1'b0, 9'h1A5);
        check("pre_start_tx", {8'b0, tx}, 9'h001);
        rd(1'b0, v); check("one_count", v, 9'h001);
        tick();
        check("start_lat", {8'b0, tx}, 9'h000);
        run_tx(0, 40, "a5");
        rd(1'b1, v); check("a5_done_stat", v, 9'h002);

        // Three back-to-back frames.
        exp_bytes[0] = 8'h11; exp_bytes[1] = 8'h22; exp_bytes[2] = 8'h33;
        wr(1'b0, 9'h011);
        wr(1'b0, 9'h022);
        rd(1'b0, v); check("b2b_count1", v, 9'h001);
        wr(1'b0, 9'h033);
        rd(1'b0, v); check("b2b_count2", v, 9'h002);
        run_tx(1, 120, "b2b");
        rd(1'b1, v); check("b2b_done_stat", v, 9'h002);

        // Overflow: six writes, only five bytes survive.
        for (int i = 0; i < 5; i++) exp_bytes[i] = 8'(i + 1);
        for (int i = 1; i <= 6; i++) wr(1'b0, 9'(i));
        rd(1'b0, v); check("ovf_count", v, 9'h004);
        rd(1'b1, v); check("ovf_stat", v, 9'h00D);
        wr(1'b1, 9'h001);
        rd(1'b1, v); check("ovf_clr_stat", v, 9'h005);
        run_tx(5, 200, "ovf");
        rd(1'b1, v); check("ovf_done_stat", v, 9'h002);

        // Push and pop on the same edge with two entries queued.
        exp_bytes[0] = 8'h41; exp_bytes[1] = 8'h42; exp_bytes[2] = 8'h43; exp_bytes[3] = 8'h44;
        wr(1'b0, 9'h041);
        wr(1'b0, 9'h042);
        wr(1'b0, 9'h043);
        rd(1'b0, v); check("pp_count_pre", v, 9'h002);
        run_tx(1, 39, "pp");
        wr(1'b0, 9'h044);
        rd(1'b0, v); check("pp_count_post", v, 9'h002);
        run_tx(40, 160, "pp");
        rd(1'b1, v); check("pp_done_stat", v, 9'h002);

        // Reset mid DATA bit 3 with a byte still queued.
        exp_bytes[0] = 8'hA5;
        wr(1'b0, 9'h0A5);
        wr(1'b0, 9'h05A);
        run_tx(0, 17, "rst");
        check("rst_bit3_tx", {8'b0, tx}, 9'h000);
        reset = 1'b1;
        #1;
        check("rst_async_tx", {8'b0, tx}, 9'h001);
        rd(1'b1, v); check("rst_stat", v, 9'h002);
        rd(1'b0, v); check("rst_count", v, 9'h000);
        tick();
        reset = 1'b0;
        line_ok = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1) line_ok = 1'b0;
        end
        check("rst_line_quiet", {8'b0, line_ok}, 9'h001);
        rd(1'b1, v); check("rst_after_stat", v, 9'h002);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
